// File: rtl/timestamper_pkg.sv
// timestamper_pkg: shared widths and FIFO entry type; TIMESTAMPER_DROP_FLAG_EN adds a drop bit to every word
package timestamper_pkg;
`ifdef TIMESTAMPER_DROP_FLAG_EN
  localparam int DROP_W = 1;
`else
  localparam int DROP_W = 0;
`endif
  localparam int TS_W = 24;
  typedef struct packed {
`ifdef TIMESTAMPER_DROP_FLAG_EN
    logic drop;
`endif
    logic [TS_W-1:0] ts;
  } fifo_entry_t;
  function automatic int ch_id_w(input int num_ch);
    return num_ch > 2 ? $clog2(num_ch) : 1;
  endfunction
  function automatic int entry_w(input int cnt_w);
    return DROP_W + cnt_w;
  endfunction
  function automatic int word_w(input int num_ch, input int cnt_w);
    return entry_w(cnt_w) + ch_id_w(num_ch);
  endfunction
endpackage

// File: rtl/multi_channel_timestamper_if.sv
// multi_channel_timestamper_if: serial readout link between the external reader (master) and the timestamper (slave)
interface multi_channel_timestamper_if;
  logic dat_clk;
  logic dat_ena;
  logic dat_rdy;
  logic dat_out;
  modport master (output dat_clk, dat_ena, input dat_rdy, dat_out);
  modport slave (input dat_clk, dat_ena, output dat_rdy, dat_out);
endinterface

// File: rtl/ts_channel_fifo.sv
// ts_channel_fifo: power-of-two circular buffer with pointers one bit wider than the address
module ts_channel_fifo #(
  parameter int W = 24,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] dout
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  assign empty = wp == rp;
  assign full = (wp ^ rp) == {1'b1, {AW{1'b0}}};
  assign dout = mem[rp[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) mem[wp[AW-1:0]] <= din;
      wp <= push ? wp + 1'b1 : wp;
      rp <= pop ? rp + 1'b1 : rp;
    end
endmodule

// File: rtl/multi_channel_timestamper.sv
// multi_channel_timestamper: per-channel edge timestamp FIFOs, round-robin arbiter, serial readout; TIMESTAMPER_DROP_FLAG_EN tags words after drops
module multi_channel_timestamper
  import timestamper_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_WIDTH = TS_W,
  parameter int FIFO_DEPTH = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_CH-1:0]    trig,
  input  logic [NUM_CH-1:0]    ch_en,
  input  logic [NUM_CH-1:0]    edge_fall,
  input  logic                 clear_ovf,
  multi_channel_timestamper_if.slave rd,
  output logic [NUM_CH-1:0]    ovf
);
  localparam int CW = ch_id_w(NUM_CH);
  localparam int EW = entry_w(CNT_WIDTH);
  localparam int WW = word_w(NUM_CH, CNT_WIDTH);
  localparam int PW = NUM_CH + 2;
  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] s, prev_q;
  logic [NUM_CH-1:0] rise_q, fall_q, ev, full, empty, push, pop, drop;
  logic load_q, dfall_q, shift, gnt_v, take;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [EW-1:0] dout [NUM_CH];
  logic [CW-1:0] rr_q, gnt;
  logic [WW-1:0] hold_q, sh_q, word;
  assign s = sync_q[SYNC_STAGES-1];
  assign ev = ch_en & ((rise_q & ~edge_fall) | (fall_q & edge_fall));
  assign shift = dfall_q & ~load_q;
  assign take = gnt_v & (~rd.dat_rdy | load_q);
  assign push = ev & (~full | pop);
  assign drop = ev & ~push;
  assign rd.dat_out = sh_q[WW-1];
  // first non-empty channel at or after rr_q; the lowest offset wins
  always_comb begin
    gnt_v = 1'b0;
    gnt = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (!empty[(int'(rr_q) + i) % NUM_CH]) begin
        gnt_v = 1'b1;
        gnt = CW'((int'(rr_q) + i) % NUM_CH);
      end
    end
  end
  always_comb begin
    pop = '0;
    for (int c = 0; c < NUM_CH; c++) pop[c] = take & (gnt == CW'(c));
  end
`ifdef TIMESTAMPER_DROP_FLAG_EN
  logic [NUM_CH-1:0] pend_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pend_q <= '0;
    else pend_q <= (pend_q | drop) & ~push;
  assign word = {dout[gnt][CNT_WIDTH], gnt, dout[gnt][CNT_WIDTH-1:0]};
`else
  assign word = {gnt, dout[gnt]};
`endif
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [EW-1:0] din;
`ifdef TIMESTAMPER_DROP_FLAG_EN
    assign din = {pend_q[g], cnt_q};
`else
    assign din = cnt_q;
`endif
    ts_channel_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk), .rst_n(rst_n), .push(push[g]), .pop(pop[g]), .din(din),
      .full(full[g]), .empty(empty[g]), .dout(dout[g])
    );
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
      rise_q <= '0;
      fall_q <= '0;
      load_q <= 1'b0;
      dfall_q <= 1'b0;
      cnt_q <= '0;
      rr_q <= '0;
      hold_q <= '0;
      sh_q <= '0;
      rd.dat_rdy <= 1'b0;
      ovf <= '0;
    end else begin
      sync_q[0] <= {rd.dat_ena, rd.dat_clk, trig};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= s;
      rise_q <= s[NUM_CH-1:0] & ~prev_q[NUM_CH-1:0];
      fall_q <= ~s[NUM_CH-1:0] & prev_q[NUM_CH-1:0];
      load_q <= s[PW-1] & ~prev_q[PW-1];
      dfall_q <= ~s[NUM_CH] & prev_q[NUM_CH];
      cnt_q <= cnt_q + 1'b1;
      rr_q <= take ? (int'(gnt) == NUM_CH - 1 ? '0 : gnt + 1'b1) : rr_q;
      hold_q <= take ? word : hold_q;
      rd.dat_rdy <= take | (rd.dat_rdy & ~load_q);
      sh_q <= load_q ? (rd.dat_rdy ? hold_q : '0) : shift ? sh_q << 1 : sh_q;
      ovf <= (clear_ovf ? '0 : ovf) | drop;
    end
endmodule

// File: doc/multi_channel_timestamper.md
Name: multi_channel_timestamper

Overview:
Multi-channel successor to the single-channel trigger timestamper. It holds NUM_CH trigger inputs, each with its own edge select and FIFO, all sharing one free-running counter. A round-robin arbiter moves tagged words {channel id, timestamp} into one output holding register. The existing serial readout protocol (dat_rdy / dat_ena / dat_clk / dat_out) drains that register. The block sits at top level between the pin wrapper and the pads.

Parameters:
- NUM_CH, 4, number of trigger channels (1..8).
- CNT_WIDTH, 24, timestamp counter width.
- FIFO_DEPTH, 4, entries per channel FIFO (power of two, 2..16).
- SYNC_STAGES, 2, synchroniser flops on every pin input.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- trig  in  NUM_CH  asynchronous trigger pins.
- ch_en  in  NUM_CH  per-channel enable. 0 = edges ignored; FIFO contents are kept.
- edge_fall  in  NUM_CH  per-channel edge select. 0 = rising, 1 = falling.
- clear_ovf  in  1  synchronous pulse that clears all overflow flags.
- dat_clk  in  1  asynchronous serial clock from the reader.
- dat_ena  in  1  asynchronous load strobe from the reader.
- dat_rdy  out  1  holding register valid.
- dat_out  out  1  serial data, MSB first.
- ovf  out  NUM_CH  sticky per-channel drop flags.

Behaviour:
- Reset: all outputs, counter, FIFOs, holding register, shift register, arbiter pointer and synchronisers go to 0.
- Widths:
  - CH_ID_W = max(1, clog2(NUM_CH)).
  - WORD_W = CH_ID_W + CNT_WIDTH.
  - Word layout = {ch_id, timestamp}.
- Counter: increments every clk and wraps modulo 2^CNT_WIDTH. No wrap marker.
- Input path:
  - trig, dat_clk and dat_ena each pass through SYNC_STAGES flops, then a registered edge detector.
  - A channel event is the selected edge on the synchronised trig with ch_en=1, detected in cycle N.
  - The stored timestamp is the counter value in cycle N. Fixed pin-to-timestamp offset = SYNC_STAGES+1 cycles; the reader subtracts it.
- FIFO push:
  - An event pushes if the FIFO is not full, or if the same channel is popped in the same cycle.
  - Otherwise the event is dropped and ovf[ch] is set.
  - ovf clears only on clear_ovf. If clear_ovf and a drop occur in the same cycle, the flag stays set.
- Arbiter:
  - When the holding register is empty (dat_rdy=0), or is being emptied this cycle, it picks the first non-empty FIFO at or after the channel following the last grant (rr_ptr).
  - It pops that FIFO, loads the holding register and sets rr_ptr = granted+1 (mod NUM_CH).
  - Latency: event in cycle N, FIFO non-empty in N+1, dat_rdy=1 in N+2 (when holding was empty and no other channel wins).
  - Simultaneous events on several channels all push in the same cycle; the arbiter emits them in round-robin order.
- Readout:
  - Rising edge of synced dat_ena: shift register <= holding word if dat_rdy=1, otherwise all-zero. dat_rdy clears the next cycle unless the arbiter refills in that same cycle.
  - Falling edge of synced dat_clk: shift register shifts left with 0 fill. The reader samples on dat_clk rising.
  - dat_out = shift register MSB.
  - A dat_clk falling edge in the same cycle as a dat_ena rise is ignored; the load wins.
  - Further dat_clk edges beyond WORD_W shift out zeros.
- ch_en deasserted mid-stream stops pushes only. Queued words still drain.
- rst_n assertion mid-readout aborts immediately; queued data is lost.

Optional Feature:
- Macro: TIMESTAMPER_DROP_FLAG_EN.
- Defined:
  - WORD_W gains one MSB, drop bit. Layout = {drop, ch_id, timestamp}.
  - drop=1 on the first word pushed into a channel FIFO after at least one drop on that channel.
  - The per-channel pending flag behind this bit is cleared when that word is pushed. It is independent of ovf and clear_ovf.
- Undefined: layout as above, no drop bit.

Decomposition:
- Package timestamper_pkg:
  - function ch_id_w(num_ch).
  - localparam-style helpers for WORD_W.
  - typedef for the per-channel FIFO entry struct {drop (conditional), timestamp}.
- One sub-module, ts_channel_fifo:
  - A FIFO_DEPTH circular buffer with push, pop, full, empty, dout.
  - Pointers one bit wider than log2(depth).
  - Instantiated NUM_CH times.
- Arbiter, counter, synchronisers and shifter stay in the top module.

Test Plan:
- Single rising edge on trig[2] with counter at 0x000100 at detection; read 26 bits (NUM_CH=4) → dat_rdy rises N+2, dat_out stream = 2'b10 then 24'h000100.
- trig[0] and trig[3] edges in the same cycle, rr_ptr=1 → words read in order ch3 then ch0, identical timestamps.
- Five events on ch1 with no readout (FIFO_DEPTH=4) → four in FIFO plus one in holding, none dropped, ovf=0. A sixth event sets ovf[1]=1. clear_ovf → ovf=0.
- edge_fall[1]=1, drive a 0→1→0 pulse → exactly one word, timestamped at the falling edge. ch_en[1]=0 → no words.
- Counter preset near wrap (run 2^24-3 cycles, or force in sim); events before and after wrap → timestamps 0xFFFFFE then 0x000001, correct order.
- dat_ena rise with dat_rdy=0 → dat_out stays 0 for 26 clocks. Assert rst_n low mid-shift → dat_out=0, dat_rdy=0, ovf=0, FIFOs empty.
